// File: rtl/fmult_share_ctrl.sv
// Two-port round-robin front end for a shared iterative FP multiplier.
// Zero operands are answered locally; a stuck multiplier is aborted after TIMEOUT cycles.
module fmult_share_ctrl #(
    parameter int unsigned DW      = 32,  // IEEE-754 single only
    parameter int unsigned TIMEOUT = 64   // 1..255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,

    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp0_err,

    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    output logic          rsp1_err,

    output logic          mul_start,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    input  logic          mul_done,
    input  logic [DW-1:0] mul_result,

    output logic          busy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [DW-1:0] QNAN    = DW'(32'h7FC0_0000);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] rsp0_data_q, rsp0_data_d;
    logic          rsp0_err_q, rsp0_err_d;
    logic [DW-1:0] rsp1_data_q, rsp1_data_d;
    logic          rsp1_err_q, rsp1_err_d;

    logic          grant;
    logic          grant_vld;
    logic          hs;
    logic [DW-1:0] hs_a;
    logic [DW-1:0] hs_b;
    logic          hs_zero;
    logic          ld_en;
    logic          ld_port;
    logic [DW-1:0] ld_data;
    logic          ld_err;

    // Handshake: a request transfers on the cycle reqX_valid && reqX_ready; ready is only
    // offered in IDLE to the granted port, and valid must hold until that cycle. Responses
    // are single-cycle pulses with no backpressure.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        req0_ready = (state_q == S_IDLE) && grant_vld && !grant;
        req1_ready = (state_q == S_IDLE) && grant_vld && grant;
        hs         = req0_ready | req1_ready;
        hs_a       = grant ? req1_a : req0_a;
        hs_b       = grant ? req1_b : req0_b;
        hs_zero    = (hs_a[DW-2:0] == '0) || (hs_b[DW-2:0] == '0);
    end

    // Next-state and result-load logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        ld_en        = 1'b0;
        ld_port      = owner_q;
        ld_data      = '0;
        ld_err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    owner_d = grant;
                    a_d     = hs_a;
                    b_d     = hs_b;
                    if (hs_zero) begin
                        // Zero beats NaN/Inf: only the sign is computed.
                        ld_en   = 1'b1;
                        ld_port = grant;
                        ld_data = {hs_a[DW-1] ^ hs_b[DW-1], {(DW-1){1'b0}}};
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mul_done) begin
                    ld_en   = 1'b1;
                    ld_data = mul_result;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    ld_en   = 1'b1;
                    ld_data = QNAN;
                    ld_err  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_grant_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results land directly in the owner's output register so data holds between pulses.
    always_comb begin
        rsp0_data_d = rsp0_data_q;
        rsp0_err_d  = rsp0_err_q;
        rsp1_data_d = rsp1_data_q;
        rsp1_err_d  = rsp1_err_q;
        if (ld_en && !ld_port) begin
            rsp0_data_d = ld_data;
            rsp0_err_d  = ld_err;
        end
        if (ld_en && ld_port) begin
            rsp1_data_d = ld_data;
            rsp1_err_d  = ld_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            rsp0_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid = (state_q == S_RESP) && owner_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_err   = rsp1_err_q;
    assign mul_start  = (state_q == S_ISSUE);
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fmult_share_ctrl.sv
// Directed bench for fmult_share_ctrl: vector table plus arbitration, reset-abort and
// early-done sequences, with a behavioural multiplier and a response scoreboard.
module tb_fmult_share_ctrl;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_data;
    logic        mul_start, mul_done;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        busy;
    logic [1:0]  dbg_state;

    fmult_share_ctrl #(.DW(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .busy(busy), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        int          dly;
        bit          early;
        logic [31:0] mres;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_starts;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [33:0] exp_q[$];
    logic [33:0] last_exp[2];
    bit          mon_en   = 0;
    int          rsp_cnt  = 0;
    int          rsp_cyc  = 0;

    int          mdl_dly    = 0;
    bit          mdl_early  = 0;
    logic [31:0] mdl_result = '0;
    int          mdl_starts = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // ---------------- multiplier model ----------------
    initial begin
        int          cnt;
        logic [31:0] pend;
        cnt = 0;
        pend = '0;
        mul_done = 0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_done = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mul_done = 1;
                    mul_result = pend;
                end
            end
            if (mul_start) begin
                mdl_starts++;
                if (mdl_early) begin
                    mul_done = 1;
                    mul_result = 32'hDEADBEEF;
                end
                cnt = mdl_dly;
                pend = mdl_result;
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && (rsp0_valid || rsp1_valid)) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                check_eq("rsp_single_port", 32'(rsp0_valid & rsp1_valid), 0);
                check_eq("rsp_expected_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("rsp_port", 32'(rsp1_valid), 32'(e[33]));
                    check_eq("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e[31:0]);
                    check_eq("rsp_err", 32'(rsp1_valid ? rsp1_err : rsp0_err), 32'(e[32]));
                    last_exp[e[33]] = e;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic port, input logic [31:0] a, input logic [31:0] b, output int t_hs);
        bit got;
        got = 0;
        t_hs = -1;
        @(posedge clk);
        #1;
        if (!port) begin
            req0_valid = 1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b;
        end
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if ((!port && req0_ready) || (port && req1_ready)) begin
                got = 1;
                t_hs = cyc;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        check_eq("handshake_seen", 32'(got), 1);
    endtask

    task automatic wait_rsp(input int prev, output bit ok);
        ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (rsp_cnt != prev) ok = 1;
        end
    endtask

    task automatic both_req();
        int exp_order[6] = '{0, 1, 0, 1, 0, 1};
        int hs_cyc[6];
        int k;
        int st0;
        k = 0;
        st0 = mdl_starts;
        mdl_dly = 3;
        mdl_result = 32'h40000000;
        @(posedge clk);
        #1;
        req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        req1_valid = 1; req1_a = 32'h3F800000; req1_b = 32'h40000000;
        for (int n = 0; n < 400 && k < 6; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check_eq($sformatf("grant%0d_ready0", k), 32'(req0_ready), 32'(exp_order[k] == 0));
                check_eq($sformatf("grant%0d_ready1", k), 32'(req1_ready), 32'(exp_order[k] == 1));
                exp_q.push_back({exp_order[k][0], 1'b0, 32'h40000000});
                hs_cyc[k] = cyc;
                if (k > 0) check_eq($sformatf("grant%0d_gap", k), hs_cyc[k] - hs_cyc[k-1], 6);
                k++;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        check_eq("both_handshakes", k, 6);
        for (int n = 0; n < 50 && exp_q.size() > 0; n++) @(negedge clk);
        #1;
        check_eq("both_rsp_drained", exp_q.size(), 0);
        check_eq("both_starts", mdl_starts - st0, 6);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t_hs, t2, st0, rc0;
        bit ok;

        vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 3,  1'b0, 32'h40000000, 32'h40000000, 1'b0, 5,  1};
        vecs[1]  = '{1'b0, 32'h80000000, 32'h40400000, 0,  1'b0, 32'h0,        32'h80000000, 1'b0, 1,  0};
        vecs[2]  = '{1'b1, 32'h40400000, 32'h00000000, 0,  1'b0, 32'h0,        32'h00000000, 1'b0, 1,  0};
        vecs[3]  = '{1'b1, 32'h80000000, 32'h80000000, 0,  1'b0, 32'h0,        32'h00000000, 1'b0, 1,  0};
        vecs[4]  = '{1'b0, 32'h7FC00000, 32'h80000000, 0,  1'b0, 32'h0,        32'h80000000, 1'b0, 1,  0};
        vecs[5]  = '{1'b1, 32'h40000000, 32'h40000000, 1,  1'b0, 32'h40800000, 32'h40800000, 1'b0, 3,  1};
        vecs[6]  = '{1'b1, 32'h3F800000, 32'h3F800000, 0,  1'b0, 32'h0,        32'h7FC00000, 1'b1, 66, 1};
        vecs[7]  = '{1'b0, 32'hC0000000, 32'h3F800000, 10, 1'b0, 32'hC0000000, 32'hC0000000, 1'b0, 12, 1};
        vecs[8]  = '{1'b1, 32'h40400000, 32'h40400000, 64, 1'b0, 32'h41100000, 32'h41100000, 1'b0, 66, 1};
        vecs[9]  = '{1'b0, 32'h3F800000, 32'h40000000, 65, 1'b0, 32'h40000000, 32'h7FC00000, 1'b1, 66, 1};
        vecs[10] = '{1'b1, 32'h40000000, 32'h40000000, 1,  1'b1, 32'h40800000, 32'h40800000, 1'b0, 3,  1};
        vecs[11] = '{1'b0, 32'h00000001, 32'h80000000, 0,  1'b0, 32'h0,        32'h80000000, 1'b0, 1,  0};
        vecs[12] = '{1'b1, 32'hFF800000, 32'h00000000, 0,  1'b0, 32'h0,        32'h80000000, 1'b0, 1,  0};

        rst = 1;
        req0_valid = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        mon_en = 1;
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_state", 32'(dbg_state), 0);
        check_eq("reset_mul_start", 32'(mul_start), 0);
        check_eq("reset_mul_a", mul_a, 0);
        check_eq("reset_mul_b", mul_b, 0);
        check_eq("reset_ready", 32'({req0_ready, req1_ready}), 0);
        check_eq("reset_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
        check_eq("reset_rsp0", {rsp0_err, rsp0_data[30:0]}, 0);
        check_eq("reset_rsp1", {rsp1_err, rsp1_data[30:0]}, 0);

        // Round-robin with both ports held valid, port 0 first after reset.
        both_req();

        for (int i = 0; i < NV; i++) begin
            mdl_dly = vecs[i].dly;
            mdl_early = vecs[i].early;
            mdl_result = vecs[i].mres;
            st0 = mdl_starts;
            rc0 = rsp_cnt;
            exp_q.push_back({vecs[i].port, vecs[i].exp_err, vecs[i].exp_data});
            do_req(vecs[i].port, vecs[i].a, vecs[i].b, t_hs);
            wait_rsp(rc0, ok);
            check_eq($sformatf("v%0d_rsp_seen", i), 32'(ok), 1);
            check_eq($sformatf("v%0d_latency", i), rsp_cyc - t_hs, vecs[i].exp_lat);
            @(negedge clk);
            check_eq($sformatf("v%0d_busy_after", i), 32'(busy), 0);
            check_eq($sformatf("v%0d_starts", i), mdl_starts - st0, vecs[i].exp_starts);
            mdl_early = 0;
        end

        check_eq("hold_rsp0_data", rsp0_data, last_exp[0][31:0]);
        check_eq("hold_rsp0_err", 32'(rsp0_err), 32'(last_exp[0][32]));
        check_eq("hold_rsp1_data", rsp1_data, last_exp[1][31:0]);
        check_eq("hold_rsp1_err", 32'(rsp1_err), 32'(last_exp[1][32]));

        // Reset during WAIT: the aborted op must not respond, its late done must be ignored.
        mdl_dly = 4;
        mdl_result = 32'h12345678;
        st0 = mdl_starts;
        rc0 = rsp_cnt;
        do_req(1'b0, 32'h3F800000, 32'h40000000, t_hs);
        @(negedge clk);
        check_eq("abort_start_pulse", 32'(mul_start), 1);
        @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        check_eq("abort_in_wait", 32'(dbg_state), 2);
        check_eq("abort_mul_a", mul_a, 32'h3F800000);
        check_eq("abort_mul_b", mul_b, 32'h40000000);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check_eq("abort_cycle", cyc - t_hs, 3);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_mul_start", 32'(mul_start), 0);
        check_eq("abort_rsp0_data", rsp0_data, 0);
        check_eq("abort_rsp0_valid", 32'(rsp0_valid), 0);
        mdl_dly = 2;
        mdl_result = 32'h40400000;
        exp_q.push_back({1'b0, 1'b0, 32'h40400000});
        do_req(1'b0, 32'h3F800000, 32'h40400000, t2);
        check_eq("after_abort_accept", t2 - t_hs, 4);
        wait_rsp(rc0, ok);
        check_eq("after_abort_rsp_seen", 32'(ok), 1);
        check_eq("after_abort_latency", rsp_cyc - t2, 4);
        check_eq("after_abort_starts", mdl_starts - st0, 2);

        repeat (5) @(negedge clk);
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
